serial_word_comparator: RTL and testbench

SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

---
 rtl/serial_word_comparator.sv | 126 ++++++++++++
 tb/tb_serial_word_comparator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_word_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_comparator
// Description : Compares two unsigned words that arrive serially, MSB first,
//               one bit pair per bit_valid cycle. The first differing bit
//               decides the relation; the result (eq/gt/lt) is published
//               one cycle after the word completes and held until the next
//               accepted start.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_comparator #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bit_valid,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic       eq,
    output logic       gt,
    output logic       lt,
    output logic [5:0] bit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [5:0] C_LAST_CNT = 6'(WIDTH);

    state_t     r_state;
    logic [5:0] r_bit_cnt;
    logic       r_decided;
    logic [1:0] r_rel;          // [1] = A greater, [0] = B greater
    logic       r_busy;
    logic       r_done;
    logic       r_result_valid;
    logic       r_eq;
    logic       r_gt;
    logic       r_lt;

    logic [5:0] w_cnt_next;
    logic       w_start_ok;

    // Count of bits after accepting the current pair.
    assign w_cnt_next = r_bit_cnt + 6'd1;

    // The cycle in which done is visible still belongs to the DONE phase
    // from the outside, so a start arriving together with done is dropped.
    assign w_start_ok = start & ~r_done;

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= 6'd0;
            r_decided      <= 1'b0;
            r_rel          <= 2'b00;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result_valid <= 1'b0;
            r_eq           <= 1'b0;
            r_gt           <= 1'b0;
            r_lt           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state        <= S_SHIFT;
                        r_busy         <= 1'b1;
                        r_bit_cnt      <= 6'd0;
                        r_decided      <= 1'b0;
                        r_rel          <= 2'b00;
                        r_result_valid <= 1'b0;
                        r_eq           <= 1'b0;
                        r_gt           <= 1'b0;
                        r_lt           <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (bit_valid) begin
                        r_bit_cnt <= w_cnt_next;
                        // Only the most significant differing bit matters.
                        if (!r_decided && (a_bit != b_bit)) begin
                            r_decided <= 1'b1;
                            r_rel     <= {a_bit, b_bit};
                        end
                        if (w_cnt_next == C_LAST_CNT) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state        <= S_IDLE;
                    r_done         <= 1'b1;
                    r_result_valid <= 1'b1;
                    r_eq           <= ~r_decided;
                    r_gt           <= r_decided & r_rel[1];
                    r_lt           <= r_decided & r_rel[0];
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = r_result_valid;
    assign eq           = r_eq;
    assign gt           = r_gt;
    assign lt           = r_lt;
    assign bit_cnt      = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_comparator
// Description : Self-checking bench for serial_word_comparator. One instance
//               at WIDTH=8 and one at WIDTH=1; expected results come from
//               plain integer comparison of the words that were shifted in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_comparator;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, bv8, a8, b8;
    logic       busy8, done8, rv8, eq8, gt8, lt8;
    logic [5:0] cnt8;

    logic       start1, bv1, a1, b1;
    logic       busy1, done1, rv1, eq1, gt1, lt1;
    logic [5:0] cnt1;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt8 = 0;

    always #5 clk = ~clk;

    serial_word_comparator #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst), .start(start8), .bit_valid(bv8),
        .a_bit(a8), .b_bit(b8), .busy(busy8), .done(done8),
        .result_valid(rv8), .eq(eq8), .gt(gt8), .lt(lt8), .bit_cnt(cnt8)
    );

    serial_word_comparator #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(rst), .start(start1), .bit_valid(bv1),
        .a_bit(a1), .b_bit(b1), .busy(busy1), .done(done1),
        .result_valid(rv1), .eq(eq1), .gt(gt1), .lt(lt1), .bit_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift one 8-bit word pair. gaps holds, per bit 1..7, the number of idle
    // cycles (0..3) following that bit. disturb adds spurious bit_valid in
    // IDLE and start pulses during SHIFT, DONE and the done cycle.
    task automatic do_word(input string tag, input logic [7:0] A, input logic [7:0] B,
                           input logic [13:0] gaps, input bit disturb);
        int cyc;
        int explat;
        explat = 10;
        for (int k = 0; k < 7; k++) explat += int'(gaps[2*k +: 2]);
        if (disturb) begin
            repeat (2) begin
                @(negedge clk);
                bv8 = 1'b1; a8 = 1'($urandom); b8 = 1'($urandom);
            end
            @(negedge clk);
            bv8 = 1'b0;
            chk({tag, "/idle_cnt"},  32'(cnt8),  32'(exp_cnt8));
            chk({tag, "/idle_busy"}, 32'(busy8), 32'd0);
        end
        @(negedge clk);
        start8 = 1'b1; bv8 = 1'b0;
        cyc = 0;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            cyc++;
            if (i == 7) begin
                chk({tag, "/busy_start"}, 32'(busy8), 32'd1);
                chk({tag, "/rv_cleared"}, 32'(rv8), 32'd0);
                chk({tag, "/res_cleared"}, 32'({eq8, gt8, lt8}), 32'd0);
            end
            start8 = disturb && (i == 4);
            bv8 = 1'b1; a8 = A[i]; b8 = B[i];
            if (i > 0) begin
                for (int g = 0; g < int'(gaps[2*(7-i) +: 2]); g++) begin
                    @(negedge clk);
                    cyc++;
                    bv8 = 1'b0; a8 = 1'($urandom); b8 = 1'($urandom);
                    start8 = disturb;
                end
            end
        end
        @(negedge clk);
        cyc++;
        bv8 = 1'b0; start8 = disturb;
        while (done8 !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(explat));
        chk({tag, "/done"}, 32'(done8), 32'd1);
        chk({tag, "/rv"},   32'(rv8),   32'd1);
        chk({tag, "/eq"},   32'(eq8),   32'(A == B));
        chk({tag, "/gt"},   32'(gt8),   32'(A > B));
        chk({tag, "/lt"},   32'(lt8),   32'(A < B));
        chk({tag, "/cnt"},  32'(cnt8),  32'd8);
        chk({tag, "/busy_end"}, 32'(busy8), 32'd0);
        exp_cnt8 = 8;
        @(negedge clk);
        start8 = 1'b0;
        chk({tag, "/done_pulse"}, 32'(done8), 32'd0);
        chk({tag, "/rv_hold"},    32'(rv8),   32'd1);
        chk({tag, "/no_restart"}, 32'(busy8), 32'd0);
        chk({tag, "/res_hold"},   32'({eq8, gt8, lt8}),
            32'({A == B, A > B, A < B}));
    endtask

    // One word on the WIDTH=1 instance, plus a check that the result is held.
    task automatic do_w1(input string tag, input logic A, input logic B);
        int cyc;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk({tag, "/rv_cleared"}, 32'(rv1), 32'd0);
        bv1 = 1'b1; a1 = A; b1 = B;
        cyc = 1;
        @(negedge clk);
        bv1 = 1'b0;
        cyc = 2;
        chk({tag, "/done_early"}, 32'(done1), 32'd0);
        while (done1 !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'd3);
        chk({tag, "/res"}, 32'({eq1, gt1, lt1}), 32'({A == B, A > B, A < B}));
        chk({tag, "/cnt"}, 32'(cnt1), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "/hold"}, 32'({rv1, done1, eq1, gt1, lt1}),
            32'({1'b1, 1'b0, A == B, A > B, A < B}));
    endtask

    initial begin
        bit saw_done;
        logic [7:0] ra, rb;
        rst = 1'b1;
        start8 = 1'b0; bv8 = 1'b0; a8 = 1'b0; b8 = 1'b0;
        start1 = 1'b0; bv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        repeat (2) @(negedge clk);
        // start and bit_valid during reset must be overridden
        start8 = 1'b1; bv8 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        chk("reset/dut8", 32'({busy8, done8, rv8, eq8, gt8, lt8, cnt8}), 32'd0);
        chk("reset/dut1", 32'({busy1, done1, rv1, eq1, gt1, lt1, cnt1}), 32'd0);
        rst = 1'b0; start8 = 1'b0; bv8 = 1'b0; start1 = 1'b0;
        @(negedge clk);

        do_word("a5_a5", 8'hA5, 8'hA5, 14'h0000, 1'b0);
        do_word("80_7f", 8'h80, 8'h7F, 14'h0000, 1'b0);
        do_word("00_01", 8'h00, 8'h01, 14'h0000, 1'b0);
        do_word("3c_3d_gaps", 8'h3C, 8'h3D, 14'h030C, 1'b0);
        do_word("3c_3d_disturb", 8'h3C, 8'h3D, 14'h030C, 1'b1);

        // reset in the middle of a word
        @(negedge clk);
        start8 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start8 = 1'b0; bv8 = 1'b1; a8 = 1'($urandom); b8 = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b1; start8 = 1'b1; bv8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0; bv8 = 1'b0;
        chk("midreset/outputs", 32'({busy8, done8, rv8, eq8, gt8, lt8, cnt8}), 32'd0);
        exp_cnt8 = 0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) saw_done = 1'b1;
        end
        chk("midreset/no_done", 32'(saw_done), 32'd0);
        do_word("ff_ff_after_reset", 8'hFF, 8'hFF, 14'h0000, 1'b0);

        // randomized words, gaps and disturbances
        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            do_word($sformatf("rand%0d", r), ra, rb, 14'($urandom), 1'($urandom));
        end

        // WIDTH=1 instance
        do_w1("w1_1_0", 1'b1, 1'b0);
        do_w1("w1_0_1", 1'b0, 1'b1);
        do_w1("w1_1_1", 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
